// File: rtl/sfr_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : sfr_bus_master
// Purpose  : Turns single core requests (byte/bit read, write and
//            read-modify-write) into strobes on an SFR bus with a fixed,
//            parameterised read latency, then returns a one-cycle response.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock, reset       rising-edge clock; asynchronous active-high reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_op[2:0]        000 WR_BYTE 001 WR_BIT 010 RD_BYTE 011 RD_BIT
//                      100 SETB 101 CLRB 110 CPLB 111 reserved
//   req_addr[7:0]      byte address (byte ops) or bit address (bit ops)
//   req_data[7:0]      WR_BYTE data;  req_bit  WR_BIT value
//   resp_valid         one-cycle completion pulse
//   resp_data[7:0]     byte read from the bus (0 for writes / reserved op)
//   resp_bit           selected bit before modification (bit ops)
//   resp_parity        XOR reduction of resp_data
//   resp_err           reserved op flag, valid with resp_valid
//   sfr_addr[7:0]      bus address
//   sfr_wdata[7:0]     byte write data (zero outside write strobes)
//   sfr_write_en       write strobe; sfr_write_bit_en marks a bit write
//   sfr_bit_out        bit write value (zero outside write strobes)
//   sfr_rd_en          read strobe;  sfr_rdata[7:0]  read data
// ============================================================================
module sfr_bus_master #(
  parameter int RD_LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  input  logic       req_bit,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_bit,
  output logic       resp_parity,
  output logic       resp_err,
  output logic [7:0] sfr_addr,
  output logic [7:0] sfr_wdata,
  output logic       sfr_write_en,
  output logic       sfr_write_bit_en,
  output logic       sfr_bit_out,
  output logic       sfr_rd_en,
  input  logic [7:0] sfr_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [2:0] OP_WR_BYTE = 3'b000;
  localparam logic [2:0] OP_WR_BIT  = 3'b001;
  localparam logic [2:0] OP_RD_BYTE = 3'b010;
  localparam logic [2:0] OP_RD_BIT  = 3'b011;
  localparam logic [2:0] OP_SETB    = 3'b100;
  localparam logic [2:0] OP_CLRB    = 3'b101;
  localparam logic [2:0] OP_CPLB    = 3'b110;
  localparam logic [2:0] OP_RSV     = 3'b111;

  // READ covers the strobe cycle plus the first latency cycle; WAIT covers
  // the remaining RD_LATENCY-1 cycles and ends when the counter hits this.
  localparam logic       ONE_CYCLE = (RD_LATENCY <= 1);
  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 2);

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] addr_q, addr_d, data_q, data_d, cap_q, cap_d;
  logic       bit_q, bit_d;
  logic [1:0] cnt_q, cnt_d;
  logic       capture;

  logic       req_ready_d, resp_valid_d, resp_bit_d, resp_parity_d, resp_err_d;
  logic [7:0] resp_data_d, sfr_addr_d, sfr_wdata_d;
  logic       sfr_write_en_d, sfr_write_bit_en_d, sfr_bit_out_d, sfr_rd_en_d;
  logic       op_is_bit, op_reads;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    capture = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          op_d   = req_op;
          addr_d = req_addr;
          data_d = req_data;
          bit_d  = req_bit;
          cnt_d  = 2'd0;
          case (req_op)
            OP_WR_BYTE, OP_WR_BIT: state_d = S_WRITE;
            // Reserved op spends one extra cycle in RESP so its response
            // lands with the same latency as a plain write.
            OP_RSV: begin
              state_d = S_RESP;
              cnt_d   = 2'd1;
            end
            default: state_d = S_READ;
          endcase
        end
      end
      S_READ: begin
        // sfr_rd_en is high only in the first READ cycle.
        if (!sfr_rd_en) begin
          if (ONE_CYCLE) begin
            capture = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 2'd0;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q >= WAIT_LAST) capture = 1'b1;
        else                    cnt_d = cnt_q + 2'd1;
      end
      S_WRITE: begin
        state_d = S_RESP;
        cnt_d   = 2'd0;
      end
      S_RESP: begin
        if (cnt_q != 2'd0) cnt_d = 2'd0;
        else               state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      cap_d   = sfr_rdata;
      cnt_d   = 2'd0;
      state_d = (op_q == OP_RD_BYTE || op_q == OP_RD_BIT) ? S_RESP : S_WRITE;
    end

    // Outputs are registered, so they are derived from the next state.
    op_is_bit = (op_d != OP_WR_BYTE) && (op_d != OP_RD_BYTE) && (op_d != OP_RSV);
    op_reads  = (op_d != OP_WR_BYTE) && (op_d != OP_WR_BIT) && (op_d != OP_RSV);

    req_ready_d        = (state_d == S_IDLE);
    sfr_rd_en_d        = (state_d == S_READ) && (state_q != S_READ);
    sfr_write_en_d     = (state_d == S_WRITE);
    sfr_write_bit_en_d = sfr_write_en_d && (op_d != OP_WR_BYTE);
    sfr_wdata_d        = (sfr_write_en_d && op_d == OP_WR_BYTE) ? data_d : 8'h00;

    sfr_addr_d = sfr_addr;
    if (sfr_rd_en_d)    sfr_addr_d = op_is_bit ? {addr_d[7:3], 3'b000} : addr_d;
    if (sfr_write_en_d) sfr_addr_d = addr_d;

    sfr_bit_out_d = 1'b0;
    if (sfr_write_en_d) begin
      case (op_d)
        OP_WR_BIT: sfr_bit_out_d = bit_d;
        OP_SETB:   sfr_bit_out_d = 1'b1;
        OP_CPLB:   sfr_bit_out_d = ~cap_d[addr_d[2:0]];
        default:   sfr_bit_out_d = 1'b0;
      endcase
    end

    resp_valid_d  = (state_d == S_RESP) && (cnt_d == 2'd0);
    resp_err_d    = resp_valid_d && (op_d == OP_RSV);
    resp_data_d   = resp_data;
    resp_bit_d    = resp_bit;
    resp_parity_d = resp_parity;
    if (resp_valid_d) begin
      resp_data_d   = op_reads ? cap_d : 8'h00;
      resp_bit_d    = (op_reads && op_is_bit) ? cap_d[addr_d[2:0]] : 1'b0;
      resp_parity_d = ^resp_data_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      op_q             <= 3'd0;
      addr_q           <= 8'h00;
      data_q           <= 8'h00;
      bit_q            <= 1'b0;
      cnt_q            <= 2'd0;
      cap_q            <= 8'h00;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_data        <= 8'h00;
      resp_bit         <= 1'b0;
      resp_parity      <= 1'b0;
      resp_err         <= 1'b0;
      sfr_addr         <= 8'h00;
      sfr_wdata        <= 8'h00;
      sfr_write_en     <= 1'b0;
      sfr_write_bit_en <= 1'b0;
      sfr_bit_out      <= 1'b0;
      sfr_rd_en        <= 1'b0;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      addr_q           <= addr_d;
      data_q           <= data_d;
      bit_q            <= bit_d;
      cnt_q            <= cnt_d;
      cap_q            <= cap_d;
      req_ready        <= req_ready_d;
      resp_valid       <= resp_valid_d;
      resp_data        <= resp_data_d;
      resp_bit         <= resp_bit_d;
      resp_parity      <= resp_parity_d;
      resp_err         <= resp_err_d;
      sfr_addr         <= sfr_addr_d;
      sfr_wdata        <= sfr_wdata_d;
      sfr_write_en     <= sfr_write_en_d;
      sfr_write_bit_en <= sfr_write_bit_en_d;
      sfr_bit_out      <= sfr_bit_out_d;
      sfr_rd_en        <= sfr_rd_en_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sfr_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfr_bus_master
// Purpose  : Directed self-checking bench. Two instances share all inputs:
//            dut_a with RD_LATENCY=1 and dut_b with RD_LATENCY=3. Inputs are
//            driven and outputs sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfr_bus_master;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_op = 3'd0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic       req_bit = 1'b0;
  logic [7:0] sfr_rdata = 8'h00;

  logic       a_req_ready, a_resp_valid, a_resp_bit, a_resp_parity, a_resp_err;
  logic [7:0] a_resp_data, a_sfr_addr, a_sfr_wdata;
  logic       a_sfr_write_en, a_sfr_write_bit_en, a_sfr_bit_out, a_sfr_rd_en;
  logic       b_req_ready, b_resp_valid, b_resp_bit, b_resp_parity, b_resp_err;
  logic [7:0] b_resp_data, b_sfr_addr, b_sfr_wdata;
  logic       b_sfr_write_en, b_sfr_write_bit_en, b_sfr_bit_out, b_sfr_rd_en;

  int checks = 0;
  int failures = 0;
  int b_writes;

  always #5 clock = ~clock;

  sfr_bus_master #(.RD_LATENCY(1)) dut_a (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .req_bit(req_bit),
    .resp_valid(a_resp_valid), .resp_data(a_resp_data), .resp_bit(a_resp_bit),
    .resp_parity(a_resp_parity), .resp_err(a_resp_err),
    .sfr_addr(a_sfr_addr), .sfr_wdata(a_sfr_wdata), .sfr_write_en(a_sfr_write_en),
    .sfr_write_bit_en(a_sfr_write_bit_en), .sfr_bit_out(a_sfr_bit_out),
    .sfr_rd_en(a_sfr_rd_en), .sfr_rdata(sfr_rdata)
  );

  sfr_bus_master #(.RD_LATENCY(3)) dut_b (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .req_bit(req_bit),
    .resp_valid(b_resp_valid), .resp_data(b_resp_data), .resp_bit(b_resp_bit),
    .resp_parity(b_resp_parity), .resp_err(b_resp_err),
    .sfr_addr(b_sfr_addr), .sfr_wdata(b_sfr_wdata), .sfr_write_en(b_sfr_write_en),
    .sfr_write_bit_en(b_sfr_write_bit_en), .sfr_bit_out(b_sfr_bit_out),
    .sfr_rd_en(b_sfr_rd_en), .sfr_rdata(sfr_rdata)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] addr,
                       input logic [7:0] data, input logic b);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    req_bit   = b;
  endtask

  initial begin
    // ---------------- reset state
    repeat (2) @(negedge clock);
    chk("rst_ready_a", a_req_ready, 1);
    chk("rst_wen_a", a_sfr_write_en, 0);
    chk("rst_ren_a", a_sfr_rd_en, 0);
    chk("rst_rvalid_a", a_resp_valid, 0);
    chk("rst_rdata_a", a_resp_data, 8'h00);
    chk("rst_addr_b", b_sfr_addr, 8'h00);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready_a", a_req_ready, 1);
    chk("post_rst_ready_b", b_req_ready, 1);

    // ---------------- WR_BYTE 0xE0 <- 0x5A
    issue(3'b000, 8'hE0, 8'h5A, 1'b0);
    @(negedge clock);
    chk("wrb_wen", a_sfr_write_en, 1);
    chk("wrb_addr", a_sfr_addr, 8'hE0);
    chk("wrb_wdata", a_sfr_wdata, 8'h5A);
    chk("wrb_biten", a_sfr_write_bit_en, 0);
    chk("wrb_ren", a_sfr_rd_en, 0);
    chk("wrb_ready", a_req_ready, 0);
    chk("wrb_wen_b", b_sfr_write_en, 1);
    req_valid = 1'b0;
    @(negedge clock);
    chk("wrb_rvalid", a_resp_valid, 1);
    chk("wrb_err", a_resp_err, 0);
    chk("wrb_wen_off", a_sfr_write_en, 0);
    chk("wrb_wdata_zero", a_sfr_wdata, 8'h00);
    @(negedge clock);
    chk("wrb_rvalid_off", a_resp_valid, 0);
    chk("wrb_ready_back", a_req_ready, 1);

    // ---------------- WR_BIT 0x81 <- 1
    issue(3'b001, 8'h81, 8'h00, 1'b1);
    @(negedge clock);
    chk("wrbit_wen", a_sfr_write_en, 1);
    chk("wrbit_biten", a_sfr_write_bit_en, 1);
    chk("wrbit_addr", a_sfr_addr, 8'h81);
    chk("wrbit_bitout", a_sfr_bit_out, 1);
    req_valid = 1'b0;
    @(negedge clock);
    chk("wrbit_rvalid", a_resp_valid, 1);
    chk("wrbit_bitout_zero", a_sfr_bit_out, 0);
    @(negedge clock);

    // ---------------- RD_BIT 0xE3, bus returns 0x08
    sfr_rdata = 8'h08;
    issue(3'b011, 8'hE3, 8'h00, 1'b0);
    @(negedge clock);
    chk("rdbit_ren", a_sfr_rd_en, 1);
    chk("rdbit_addr", a_sfr_addr, 8'hE0);
    chk("rdbit_wen", a_sfr_write_en, 0);
    chk("rdbit_ren_b", b_sfr_rd_en, 1);
    chk("rdbit_addr_b", b_sfr_addr, 8'hE0);
    req_valid = 1'b0;
    @(negedge clock);
    chk("rdbit_ren_once", a_sfr_rd_en, 0);
    chk("rdbit_rvalid_early", a_resp_valid, 0);
    @(negedge clock);
    chk("rdbit_rvalid", a_resp_valid, 1);
    chk("rdbit_rdata", a_resp_data, 8'h08);
    chk("rdbit_rbit", a_resp_bit, 1);
    chk("rdbit_parity", a_resp_parity, 1);
    chk("rdbit_err", a_resp_err, 0);
    chk("rdbit_rvalid_b_early", b_resp_valid, 0);
    @(negedge clock);
    chk("rdbit_rvalid_off", a_resp_valid, 0);
    chk("rdbit_rdata_hold", a_resp_data, 8'h08);
    chk("rdbit_rvalid_b_early2", b_resp_valid, 0);
    @(negedge clock);
    chk("rdbit_rvalid_b", b_resp_valid, 1);
    chk("rdbit_rdata_b", b_resp_data, 8'h08);
    chk("rdbit_rbit_b", b_resp_bit, 1);
    @(negedge clock);

    // ---------------- CPLB 0xD7, bus returns 0x80
    sfr_rdata = 8'h80;
    b_writes = 0;
    issue(3'b110, 8'hD7, 8'h00, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      if (k == 1) req_valid = 1'b0;
      chk("cplb_overlap_a", a_sfr_rd_en & a_sfr_write_en, 0);
      chk("cplb_overlap_b", b_sfr_rd_en & b_sfr_write_en, 0);
      if (b_sfr_write_en) b_writes++;
      if (k == 1) chk("cplb_raddr_a", a_sfr_addr, 8'hD0);
      if (k == 3) begin
        chk("cplb_wen_a", a_sfr_write_en, 1);
        chk("cplb_bitout_a", a_sfr_bit_out, 0);
      end
      if (k == 4) chk("cplb_rbit_a", a_resp_bit, 1);
      if (k == 5) begin
        chk("cplb_wen_b", b_sfr_write_en, 1);
        chk("cplb_biten_b", b_sfr_write_bit_en, 1);
        chk("cplb_waddr_b", b_sfr_addr, 8'hD7);
        chk("cplb_bitout_b", b_sfr_bit_out, 0);
      end
      if (k == 6) begin
        chk("cplb_rvalid_b", b_resp_valid, 1);
        chk("cplb_rbit_b", b_resp_bit, 1);
        chk("cplb_rdata_b", b_resp_data, 8'h80);
        chk("cplb_parity_b", b_resp_parity, 1);
      end
    end
    chk("cplb_one_write_b", 8'(b_writes), 8'd1);

    // ---------------- CLRB 0x0A, bus returns 0xFF
    sfr_rdata = 8'hFF;
    issue(3'b101, 8'h0A, 8'h00, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      if (k == 1) begin
        req_valid = 1'b0;
        chk("clrb_raddr_a", a_sfr_addr, 8'h08);
      end
      if (k == 3) begin
        chk("clrb_waddr_a", a_sfr_addr, 8'h0A);
        chk("clrb_bitout_a", a_sfr_bit_out, 0);
      end
      if (k == 4) begin
        chk("clrb_rbit_a", a_resp_bit, 1);
        chk("clrb_rdata_a", a_resp_data, 8'hFF);
        chk("clrb_parity_a", a_resp_parity, 0);
      end
    end

    // ---------------- back-to-back RD_BYTE with req_valid held high
    sfr_rdata = 8'h3C;
    issue(3'b010, 8'h55, 8'h00, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) begin
        chk("b2b_ren1", a_sfr_rd_en, 1);
        chk("b2b_addr1", a_sfr_addr, 8'h55);
        req_addr = 8'h66;
      end
      if (k >= 1 && k <= 3) chk("b2b_ready_busy", a_req_ready, 0);
      if (k == 3) begin
        chk("b2b_rvalid1", a_resp_valid, 1);
        chk("b2b_rdata1", a_resp_data, 8'h3C);
        chk("b2b_parity1", a_resp_parity, 0);
      end
      if (k == 4) begin
        chk("b2b_ready_idle", a_req_ready, 1);
        chk("b2b_no_ren_resp", a_sfr_rd_en, 0);
        chk("b2b_ready_busy_b", b_req_ready, 0);
      end
      if (k == 5) begin
        chk("b2b_ren2", a_sfr_rd_en, 1);
        chk("b2b_addr2", a_sfr_addr, 8'h66);
        chk("b2b_rvalid_b", b_resp_valid, 1);
        req_valid = 1'b0;
      end
      if (k == 7) chk("b2b_rvalid2", a_resp_valid, 1);
    end

    // ---------------- reset in WAIT during SETB (dut_b)
    sfr_rdata = 8'h00;
    issue(3'b100, 8'h21, 8'h00, 1'b0);
    repeat (3) begin
      @(negedge clock);
      req_valid = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("rstw_wen_b", b_sfr_write_en, 0);
    chk("rstw_ren_b", b_sfr_rd_en, 0);
    chk("rstw_wen_a", a_sfr_write_en, 0);
    chk("rstw_rdata_b", b_resp_data, 8'h00);
    chk("rstw_addr_b", b_sfr_addr, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 1) chk("rstw_ready_b", b_req_ready, 1);
      chk("rstw_no_write_b", b_sfr_write_en, 0);
      chk("rstw_no_resp_b", b_resp_valid, 0);
    end

    // ---------------- reserved op 111
    issue(3'b111, 8'h12, 8'h00, 1'b0);
    @(negedge clock);
    req_valid = 1'b0;
    chk("rsv_rvalid_early", a_resp_valid, 0);
    chk("rsv_strobes1", {a_sfr_rd_en, a_sfr_write_en, b_sfr_rd_en, b_sfr_write_en}, 0);
    chk("rsv_ready_busy", a_req_ready, 0);
    @(negedge clock);
    chk("rsv_rvalid", a_resp_valid, 1);
    chk("rsv_err", a_resp_err, 1);
    chk("rsv_err_b", b_resp_err, 1);
    chk("rsv_strobes2", {a_sfr_rd_en, a_sfr_write_en, b_sfr_rd_en, b_sfr_write_en}, 0);
    @(negedge clock);
    chk("rsv_err_off", a_resp_err, 0);
    chk("rsv_ready_back", a_req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sfr_bus_master.md
SFR_BUS_MASTER -- requirements
Module: sfr_bus_master

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, meaning cycles from the sfr_rd_en strobe until sfr_rdata is valid (legal 1..4).
REQ-002 SHALL have ports, in this order:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  core request present.
- req_ready  output  1  block can accept a request.
- req_op  input  3  000 WR_BYTE, 001 WR_BIT, 010 RD_BYTE, 011 RD_BIT, 100 SETB, 101 CLRB, 110 CPLB, 111 reserved.
- req_addr  input  8  byte address for byte ops; bit address for bit ops.
- req_data  input  8  write data for WR_BYTE.
- req_bit  input  1  write value for WR_BIT.
- resp_valid  output  1  one-cycle completion pulse.
- resp_data  output  8  read byte; for bit ops, the full byte read.
- resp_bit  output  1  selected bit value before modification.
- resp_parity  output  1  XOR of resp_data.
- resp_err  output  1  set with resp_valid for a reserved op.
- sfr_addr  output  8  SFR bus address.
- sfr_wdata  output  8  SFR byte write data.
- sfr_write_en  output  1  SFR write strobe.
- sfr_write_bit_en  output  1  qualifies a write as a bit write.
- sfr_bit_out  output  1  SFR bit write value.
- sfr_rd_en  output  1  SFR read strobe.
- sfr_rdata  input  8  SFR read data.

Function
REQ-003 SHALL drive all outputs from registers.
REQ-004 SHALL implement FSM states IDLE, READ, WAIT, WRITE and RESP.
REQ-005 SHALL assert req_ready only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-006 SHALL latch req_op, req_addr, req_data and req_bit on acceptance and ignore these inputs until the next IDLE.
REQ-007 SHALL, on accept, go IDLE->WRITE for WR_BYTE/WR_BIT, IDLE->READ for RD_BYTE/RD_BIT/SETB/CLRB/CPLB, and IDLE->RESP for op 111.
REQ-008 SHALL, for an op 111 request, issue no SFR strobe.
REQ-009 SHALL, in READ, assert sfr_rd_en for exactly one cycle.
- sfr_addr = latched addr for byte ops.
- sfr_addr = {addr[7:3],3'b000} for bit ops.
REQ-010 SHALL, in WAIT, count RD_LATENCY-1 further cycles with a 2-bit counter (WAIT skipped when RD_LATENCY=1).
- Capture sfr_rdata on the edge ending the RD_LATENCY-th cycle after the sfr_rd_en cycle.
REQ-011 SHALL set resp_bit = captured_byte[addr[2:0]] for bit ops and 0 for byte ops.
REQ-012 SHALL, after capture, go to RESP for RD_BYTE/RD_BIT and to WRITE for SETB/CLRB/CPLB.
REQ-013 SHALL, in WRITE, assert sfr_write_en for exactly one cycle.
- WR_BYTE: sfr_write_bit_en=0, sfr_addr = addr, sfr_wdata = data.
- Bit ops: sfr_write_bit_en=1, sfr_addr = full bit address.
REQ-014 SHALL drive sfr_bit_out as follows:
- WR_BIT: req_bit.
- SETB: 1.
- CLRB: 0.
- CPLB: the inverse of the captured bit.
REQ-015 SHALL, in RESP, assert resp_valid for one cycle with resp_data, resp_bit, resp_parity and resp_err stable, then return to IDLE.
- The response is not backpressured.
REQ-016 SHALL give these latencies from the accept edge N:
- Write ops: strobe in cycle N+1, resp_valid in N+2.
- Reads: sfr_rd_en in N+1, resp_valid in N+2+RD_LATENCY.
- SETB/CLRB/CPLB: write strobe in N+2+RD_LATENCY, resp_valid in N+3+RD_LATENCY.
REQ-017 SHALL drive sfr_write_en, sfr_write_bit_en and sfr_rd_en to 0 outside their strobe cycles, and never assert sfr_rd_en and sfr_write_en together.
REQ-018 SHALL hold resp_data, resp_bit and resp_parity until the next response.
REQ-019 SHALL zero sfr_wdata and sfr_bit_out outside WRITE.
REQ-020 SHALL, for an accept edge where req_valid rises in the same cycle as resp_valid, not accept the request; acceptance waits for the first IDLE cycle.

Reset
REQ-021 SHALL, on reset assertion at any state, asynchronously force IDLE, clear all strobes, zero all resp_* and sfr_* outputs and the wait counter, and discard any in-flight request.
REQ-022 SHALL raise req_ready in the first cycle after reset deasserts.

Verification
REQ-023 SHALL check WR_BYTE, addr 0xE0, data 0x5A -> one cycle sfr_write_en=1 with sfr_addr=0xE0 and sfr_wdata=0x5A, then resp_valid with resp_err=0.
REQ-024 SHALL check RD_BIT, addr 0xE3, sfr_rdata=0x08, RD_LATENCY=1 -> sfr_rd_en with sfr_addr=0xE0, then resp_valid 3 cycles after accept with resp_data=0x08, resp_bit=1 and resp_parity=1.
REQ-025 SHALL check CPLB, addr 0xD7, sfr_rdata=0x80, RD_LATENCY=3 -> bit write with sfr_addr=0xD7 and sfr_bit_out=0, then resp_bit=1, with no overlap of strobes.
REQ-026 SHALL check back-to-back requests with req_valid held high -> req_ready low while busy and the second request accepted only in IDLE after resp_valid.
REQ-027 SHALL check reset asserted in WAIT during a SETB -> strobes low immediately, no write issued, and req_ready=1 one cycle after release.
REQ-028 SHALL check op 111 -> resp_valid with resp_err=1 two cycles after accept and no SFR strobes.
